// File: rtl/bcd_convert_arbiter.sv
// One shared double-dabble binary-to-BCD converter serving two requesters
// under round-robin arbitration; one conversion per WIDTH+1 cycles.
module bcd_convert_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] value0,
   input  logic [WIDTH-1:0] value1,
   output logic             ack0,
   output logic             ack1,
   output logic             busy,
   output logic             grant_id,
   output logic [3:0]       ones,
   output logic [3:0]       tens,
   output logic [3:0]       hundreds
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam int SR_W = 12 + WIDTH;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   state_t           state_next;
   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  sr_next;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             elig0;
   logic             elig1;
   logic             capture;
   logic             winner;
   logic             last_shift;

   // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
   function automatic logic [11:0] dabble_fix(input logic [11:0] acc);
      logic [11:0] res;
      res = acc;
      for (int d = 0; d < 3; d++) begin
         if (acc[d*4 +: 4] >= 4'd5)
            res[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
      return res;
   endfunction

   always_comb begin
      elig0      = req0 & ~ack0;
      elig1      = req1 & ~ack1;
      capture    = (state == IDLE) && (elig0 || elig1);
      winner     = (elig0 && elig1) ? ~last_grant : elig1;
      last_shift = (state == SHIFT) && (cnt == LAST_CNT);
      // The top bit falls off the 12-bit accumulator; it is never set for WIDTH <= 9.
      sr_next    = {dabble_fix(sr[SR_W-1:WIDTH]), sr[WIDTH-1:0]} << 1;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (capture)    state_next = SHIFT;
         SHIFT:   if (last_shift) state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         busy       <= 1'b0;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         ones       <= 4'd0;
         tens       <= 4'd0;
         hundreds   <= 4'd0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         if (capture) begin
            grant_id   <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
            cnt        <= '0;
         end else if (last_shift) begin
            ones     <= sr_next[WIDTH +: 4];
            tens     <= sr_next[WIDTH+4 +: 4];
            hundreds <= sr_next[WIDTH+8 +: 4];
            ack0     <= ~grant_id;
            ack1     <= grant_id;
            // busy stays high through the ack cycle.
            busy     <= 1'b1;
         end else if (state == IDLE) begin
            busy <= 1'b0;
         end
         if (state == SHIFT && !last_shift)
            cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (capture)
         sr <= {12'd0, (winner ? value1 : value0)};
      else if (state == SHIFT)
         sr <= sr_next;
   end

endmodule
